// File: rtl/calc_pkg.sv
// Shared state encodings, command codes and display constants for the demo-board calculator.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_READY   = 3'b001,
    ST_LOAD_A  = 3'b010,
    ST_LOAD_B  = 3'b011,
    ST_COMPUTE = 3'b100,
    ST_DONE    = 3'b101
  } state_t;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_A  = 3'b001;
  localparam logic [2:0] OP_LOAD_B  = 3'b011;
  localparam logic [2:0] OP_COMPUTE = 3'b101;

  localparam logic [1:0] CO_ADD = 2'b00;
  localparam logic [1:0] CO_SUB = 2'b01;
  localparam logic [1:0] CO_MUL = 2'b10;
  localparam logic [1:0] CO_DIV = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern (bit0=a .. bit6=g); purely combinational.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calculator.sv
// FSM 4-bit calculator: operands loaded on enter edges, one-cycle compute, decimal 7-seg display.
// CALC_BLANK_LEADING_ZERO_EN blanks leading-zero hundreds/tens digits.
module calculator
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       enter,
  input  logic [3:0] data_in,
  input  logic [2:0] op_code,
  input  logic [1:0] compute_op,
  output logic [7:0] result,
  output logic       done,
  output logic       negative,
  output logic       div_by_zero,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [2:0] HEX3
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_READY   = ST_READY;
  localparam logic [2:0] S_LOAD_A  = ST_LOAD_A;
  localparam logic [2:0] S_LOAD_B  = ST_LOAD_B;
  localparam logic [2:0] S_COMPUTE = ST_COMPUTE;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0] state;
  logic [3:0] a, b;
  logic       enter_q;
  logic       enter_rise;
  logic [7:0] alu_res;
  logic       alu_neg;
  logic       alu_dbz;

  assign enter_rise = enter & ~enter_q;

  always_comb begin
    alu_res = '0;
    alu_neg = 1'b0;
    alu_dbz = 1'b0;
    case (compute_op)
      CO_ADD: alu_res = {4'd0, a} + {4'd0, b};
      CO_SUB: begin
        if (a < b) begin
          alu_res = {4'd0, b - a};
          alu_neg = 1'b1;
        end else begin
          alu_res = {4'd0, a - b};
        end
      end
      CO_MUL: alu_res = {4'd0, a} * {4'd0, b};
      default: begin
        // Guard the divider so B=0 never produces an undefined quotient.
        if (b == 4'd0) alu_dbz = 1'b1;
        else           alu_res = {4'd0, a / b};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      a           <= '0;
      b           <= '0;
      result      <= '0;
      negative    <= 1'b0;
      div_by_zero <= 1'b0;
      enter_q     <= 1'b0;
    end else begin
      enter_q <= enter;
      case (state)
        S_IDLE: if (start) state <= S_READY;
        S_READY, S_DONE: begin
          if (enter_rise && op_code == OP_LOAD_A) begin
            state <= S_LOAD_A;
            a     <= data_in;
          end else if (enter_rise && op_code == OP_LOAD_B) begin
            state <= S_LOAD_B;
            b     <= data_in;
          end else if (state == S_READY && op_code == OP_COMPUTE) begin
            state <= S_COMPUTE;
          end else if (state == S_DONE && op_code == OP_NOP) begin
            state <= S_READY;
          end
        end
        S_LOAD_A, S_LOAD_B: state <= S_READY;
        S_COMPUTE: begin
          result      <= alu_res;
          negative    <= alu_neg;
          div_by_zero <= alu_dbz;
          state       <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done = (state == S_DONE);
  assign HEX3 = state;

  logic [3:0] hund, tens, ones;
  logic [6:0] seg_hund, seg_tens, seg_ones;

  assign hund = 4'(result / 8'd100);
  assign tens = 4'((result / 8'd10) % 8'd10);
  assign ones = 4'(result % 8'd10);

  seg7_decoder u_seg_hund (.bcd(hund), .seg(seg_hund));
  seg7_decoder u_seg_tens (.bcd(tens), .seg(seg_tens));
  seg7_decoder u_seg_ones (.bcd(ones), .seg(seg_ones));

  assign HEX0 = seg_ones;
`ifdef CALC_BLANK_LEADING_ZERO_EN
  assign HEX2 = (hund == 4'd0) ? SEG_BLANK : seg_hund;
  assign HEX1 = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_tens;
`else
  assign HEX2 = seg_hund;
  assign HEX1 = seg_tens;
`endif

endmodule

// File: tb/tb_calculator.sv
// Calculator bench: random load/compute sequences against an arithmetic reference model via a scoreboard.
module tb_calculator;

  logic       clk, reset, start, enter;
  logic [3:0] data_in;
  logic [2:0] op_code;
  logic [1:0] compute_op;
  logic [7:0] result;
  logic       done, negative, div_by_zero;
  logic [6:0] HEX0, HEX1, HEX2;
  logic [2:0] HEX3;

  calculator dut (
    .clk(clk), .reset(reset), .start(start), .enter(enter), .data_in(data_in),
    .op_code(op_code), .compute_op(compute_op), .result(result), .done(done),
    .negative(negative), .div_by_zero(div_by_zero),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       neg;
    logic       dbz;
    logic [6:0] h0;
    logic [6:0] h1;
    logic [6:0] h2;
  } exp_t;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   a_m = 0, b_m = 0;
  bit   in_done = 0;

  function automatic exp_t model(input int a, input int b, input int cop);
    exp_t e;
    int r, t, h;
    r = 0;
    e = '0;
    case (cop)
      0: r = a + b;
      1: begin r = (a >= b) ? a - b : b - a; e.neg = (a < b); end
      2: r = a * b;
      default: if (b == 0) e.dbz = 1'b1; else r = a / b;
    endcase
    h = r / 100;
    t = (r / 10) % 10;
    e.res = r[7:0];
    e.h0  = seg_tab[r % 10];
`ifdef CALC_BLANK_LEADING_ZERO_EN
    e.h2 = (h == 0) ? 7'b1111111 : seg_tab[h];
    e.h1 = (h == 0 && t == 0) ? 7'b1111111 : seg_tab[t];
`else
    e.h2 = seg_tab[h];
    e.h1 = seg_tab[t];
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge of done consumes one expected compute result.
  initial begin
    exp_t e;
    logic done_q;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: done rose with no compute outstanding at %0t", $time);
        end else begin
          e = q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("negative", 32'(negative), 32'(e.neg));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          check("HEX0", 32'(HEX0), 32'(e.h0));
          check("HEX1", 32'(HEX1), 32'(e.h1));
          check("HEX2", 32'(HEX2), 32'(e.h2));
          check("HEX3_done", 32'(HEX3), 32'd5);
        end
      end
      done_q = done;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Enter may be held for extra cycles with changing data; only the first edge may load.
  task automatic load(input int op, input int val);
    op_code = op[2:0];
    data_in = val[3:0];
    enter   = 1'b1;
    start   = 1'($urandom_range(1));
    if (op == 1) a_m = val; else b_m = val;
    @(negedge clk);
    repeat ($urandom_range(2)) begin
      data_in = 4'($urandom);
      @(negedge clk);
    end
    enter   = 1'b0;
    start   = 1'b0;
    op_code = 3'b000;
    data_in = 4'($urandom);
    @(negedge clk);
    in_done = 0;
  endtask

  // Holding op 101 in DONE must not recompute; a stray recompute shows as an unexpected done.
  task automatic compute(input int cop, input bit stay);
    if (in_done) begin
      op_code = 3'b000;
      @(negedge clk);
    end
    compute_op = cop[1:0];
    op_code    = 3'b101;
    q.push_back(model(a_m, b_m, cop));
    @(negedge clk);
    repeat (1 + $urandom_range(2)) @(negedge clk);
    if (!stay) begin
      op_code = 3'b000;
      @(negedge clk);
      in_done = 0;
    end else begin
      in_done = 1;
    end
  endtask

  initial begin
    exp_t z;
    reset = 1'b1; start = 1'b0; enter = 1'b0; data_in = '0; op_code = '0; compute_op = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    z = model(0, 0, 0);
    check("reset_HEX3", 32'(HEX3), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_negative", 32'(negative), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    check("reset_HEX0", 32'(HEX0), 32'(z.h0));
    check("reset_HEX1", 32'(HEX1), 32'(z.h1));
    check("reset_HEX2", 32'(HEX2), 32'(z.h2));

    // Compute command with an enter pulse before start must leave IDLE untouched.
    op_code = 3'b101; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_HEX3", 32'(HEX3), 32'd0);
    check("idle_result", 32'(result), 32'd0);
    op_code = 3'b000;
    @(negedge clk);

    do_start();
    check("ready_HEX3", 32'(HEX3), 32'd1);
    load(1, 5); load(3, 2); compute(1, 0);
    load(1, 3); load(3, 7); compute(1, 0);
    load(1, 6); load(3, 3); compute(3, 1);
    load(3, 0); compute(3, 0);
    load(1, 7); load(3, 8); compute(0, 0);
    load(1, 4); load(3, 5); compute(2, 0);

    for (int i = 0; i < 80; i++) begin
      int sel;
      sel = $urandom_range(3);
      if (sel == 0 || sel == 2) load(1, $urandom_range(15));
      if (sel == 1 || sel == 2) load(3, ($urandom_range(4) == 0) ? 0 : $urandom_range(15));
      if ($urandom_range(5) == 0 && !in_done) begin
        op_code = 3'($urandom_range(1) ? 3'b010 : 3'b110);
        enter   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
        op_code = 3'b000;
        @(negedge clk);
      end
      compute($urandom_range(3), 1'($urandom_range(1)));
    end

    // Asynchronous reset from DONE clears everything without waiting for a clock edge.
    load(1, 3); load(3, 7); compute(1, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_HEX3", 32'(HEX3), 32'd0);
    check("areset_result", 32'(result), 32'd0);
    check("areset_done", 32'(done), 32'd0);
    check("areset_negative", 32'(negative), 32'd0);
    check("areset_dbz", 32'(div_by_zero), 32'd0);
    check("areset_HEX0", 32'(HEX0), 32'(z.h0));
    @(negedge clk);
    reset = 1'b0; a_m = 0; b_m = 0; in_done = 0;
    op_code = 3'b000;
    @(negedge clk);
    do_start();
    compute(2, 0);
    load(1, 9); compute(2, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
